prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits between a byte-stream source (a UART receiver or testbench) and the core's instruction memory. It writes the memory that the core fetch path reads. It parses a length-prefixed byte stream, packs bytes little-endian into 32-bit words, and writes them to consecutive word addresses. It holds the core in reset until the image is complete, then releases it; a malformed length parks it in an error state.

## Interface
- D_WIDTH, 32: instruction word width; fixed at 32, 4 bytes per word.
- A_WIDTH, 8: instruction memory word-address width; capacity is 2^A_WIDTH words.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to load a new image; honoured only in DONE.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  A_WIDTH  word address of the write.
- mem_wdata  output  D_WIDTH  word written.
- cpu_rst  output  1  active-high reset to the core; asserted while loading.
- done  output  1  image fully written.
- err  output  1  length exceeded capacity.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes, each word little-endian (first byte is bits [7:0]).
- A byte transfers on a rising edge with byte_valid && byte_ready; no other edge consumes a byte.
- FSM states: LEN_LO, LEN_HI, DATA, DONE, ERR.
  - LEN_LO: capture N[7:0] -> LEN_HI.
  - LEN_HI: capture N[15:8].
    - N == 0 -> DONE.
    - N > 2^A_WIDTH -> ERR.
    - Otherwise -> DATA, with word index 0 and byte index 0.
  - DATA: shift each byte into the word register at position byte_idx*8. On the 4th byte, write the word and increment the word index (A_WIDTH+1 bits; no wrap because N ≤ capacity). When the last word is written -> DONE.
  - DONE: byte_ready = 0, done = 1. A reload pulse -> LEN_LO, with cpu_rst re-asserted and done cleared on the same edge.
  - ERR: byte_ready = 1, so all bytes are accepted and discarded. err = 1, cpu_rst = 1. Only rst exits this state.
- byte_ready = 1 in LEN_LO, LEN_HI, DATA and ERR; 0 in DONE. The loader never stalls mid-image.
- Reset values:
  - State LEN_LO, so byte_ready = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rst = 1, done = 0, err = 0.
- rst asserted mid-image: abandon the partial word, make no further writes, and return to LEN_LO. Words already written are not cleared.
- reload outside DONE is ignored. byte_valid in DONE is ignored, since byte_ready = 0.

## Timing
- mem_we, mem_addr and mem_wdata are registered. The edge that accepts a word's 4th byte asserts mem_we for exactly the following cycle, with mem_addr = word index and mem_wdata = the assembled word.
- Back-to-back bytes: one write every 4 cycles minimum. Byte throughput is 1 per cycle.
- mem_we is 0 in every cycle not immediately following a 4th-byte accept.
- The final-word edge enters DONE. done rises in the mem_we cycle, and cpu_rst falls one cycle later, so the core leaves reset only after the last write has landed.
- The N == 0 case: done rises the cycle after the LEN_HI accept, and cpu_rst falls the next cycle. No mem_we is issued.
- ERR entry: err rises the cycle after the LEN_HI accept.

## Structure
- Package prog_loader_pkg:
  - State enum (LEN_LO, LEN_HI, DATA, DONE, ERR).
  - BYTES_PER_WORD = 4.
  - Length-field width of 16.
- One natural sub-module, byte_packer: a 2-bit byte index and a 32-bit shift/insert register. Its outputs are word_valid (on the 4th byte) and word. It clears on an FSM-driven restart.
- Top-level FSM, word counter and output registers stay in prog_loader.

## Test plan
- Stream 02 00 13 05 A0 00 93 05 15 00 -> mem_we pulses at addr 0 with 0x00A00513 and at addr 1 with 0x00150593. done = 1 in the second mem_we cycle, then cpu_rst = 0 on the next cycle.
- Stream 00 00 -> no mem_we. done = 1 the cycle after the LEN_HI accept, then cpu_rst falls. A following byte_valid sees byte_ready = 0.
- With A_WIDTH = 8, stream 01 01 (N = 257) -> err = 1 and cpu_rst stays 1. The next 8 bytes are accepted with no mem_we. Only rst recovers.
- Stream 01 00 with data bytes separated by byte_valid = 0 gaps -> the word 0xDEADBEEF (bytes EF BE AD DE) is written once at addr 0. The gaps consume nothing.
- Assert rst after 2 data bytes of a 1-word image, then release and resend the full stream -> exactly one mem_we, containing the new word only. All outputs return to their reset values during rst.
- After DONE, pulse reload and send 01 00 78 56 34 12 -> cpu_rst = 1 and done = 0 on the reload edge. Then addr 0 is written with 0x12345678 and the core is released again.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface prog_loader_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) ();

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word/word_valid
// present the completed word combinationally on the 4th byte.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (idx_q == 2'(i)) word_d[i*8 +: 8] = byte_in;
    end
    if (clear) begin
      idx_d = '0;
    end else if (byte_en) begin
      idx_d = idx_q + 2'd1;
    end
  end

  assign word       = word_d;
  assign word_valid = byte_en && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx_q <= '0;
    else      idx_q <= idx_d;
  end

  // Every byte lane is rewritten before word_valid, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (byte_en && !clear) word_q <= word_d;
  end

endmodule

// File: rtl/prog_loader.sv
// Parses a length-prefixed byte stream, writes the image to instruction
// memory and holds the core in reset until the last word has landed.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.master  bus,
  input  logic           reload,
  output logic           cpu_rst,
  output logic           done,
  output logic           err
);

  localparam int unsigned CAP = 32'd1 << A_WIDTH;
  localparam logic [A_WIDTH:0] WIDX_ONE = {{A_WIDTH{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [A_WIDTH:0]   widx_q, widx_d;
  logic               mem_we_q, mem_we_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               byte_ready;
  logic               accept;
  logic [LEN_W-1:0]   len_full;
  logic               word_valid;
  logic [WORD_W-1:0]  word;

  assign byte_ready = (state_q != ST_DONE);
  assign accept     = bus.byte_valid && byte_ready;
  assign len_full   = {bus.byte_data, len_lo_q};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q != ST_DATA),
    .byte_en    (accept && (state_q == ST_DATA)),
    .byte_in    (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.byte_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          n_d    = len_full;
          widx_d = '0;
          if (len_full == '0)              state_d = ST_DONE;
          else if (32'(len_full) > CAP)    state_d = ST_ERR;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = widx_q[A_WIDTH-1:0];
          mem_wdata_d = word;
          widx_d      = widx_q + WIDX_ONE;
          if (32'(widx_q) + 32'd1 == 32'(n_q)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (reload) state_d = ST_LEN_LO;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: state_d = ST_LEN_LO;
    endcase

    // The core stays in reset for one cycle after entering DONE so the last write lands first.
    cpu_rst_d = !((state_q == ST_DONE) && (state_d == ST_DONE));
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LEN_LO;
      len_lo_q    <= '0;
      n_q         <= '0;
      widx_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      widx_q      <= widx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream-level reference model predicts
// every output each cycle, and literal expectations pin directed images.
module tb_prog_loader;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reload = 1'b0;
  logic cpu_rst, done, err;

  prog_loader_if #(.D_WIDTH(32), .A_WIDTH(AW)) bus ();

  prog_loader #(.D_WIDTH(32), .A_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .reload  (reload),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t dut_log[$];
  wr_t mdl_log[$];
  logic [7:0] tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: interprets the byte stream by count of accepted bytes.
  int         cnt, n_len, m_addr;
  bit         m_done, m_err, m_we, m_cpu_rst, nd;
  logic [31:0] m_wdata;
  logic [7:0] lb[2];
  logic [7:0] wb[4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt = 0; n_len = 0; m_done = 0; m_err = 0; m_we = 0;
      m_addr = 0; m_wdata = '0; m_cpu_rst = 1;
    end else begin
      nd   = m_done;
      m_we = 0;
      if (m_done) begin
        if (reload) begin nd = 0; cnt = 0; end
      end else if (bus.byte_valid && !m_err) begin
        if (cnt < 2) lb[cnt] = bus.byte_data;
        else         wb[(cnt - 2) % 4] = bus.byte_data;
        cnt++;
        if (cnt == 2) begin
          n_len = int'(lb[0]) + 256 * int'(lb[1]);
          if (n_len == 0)              nd = 1;
          else if (n_len > (1 << AW))  m_err = 1;
        end else if (cnt > 2 && (cnt - 2) % 4 == 0) begin
          m_we    = 1;
          m_addr  = (cnt - 2) / 4 - 1;
          m_wdata = {wb[3], wb[2], wb[1], wb[0]};
          mdl_log.push_back('{32'(m_addr), m_wdata});
          if ((cnt - 2) / 4 == n_len) nd = 1;
        end
      end
      m_cpu_rst = !(m_done && nd);
      m_done    = nd;
    end
  end

  always @(negedge clk) begin
    chk("byte_ready", 32'(bus.byte_ready), 32'(!m_done));
    chk("mem_we",     32'(bus.mem_we),     32'(m_we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(m_addr));
    chk("mem_wdata",  bus.mem_wdata,       m_wdata);
    chk("cpu_rst",    32'(cpu_rst),        32'(m_cpu_rst));
    chk("done",       32'(done),           32'(m_done));
    chk("err",        32'(err),            32'(m_err));
    if (bus.mem_we) dut_log.push_back('{32'(bus.mem_addr), bus.mem_wdata});
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap, input bit spur);
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    reload = spur && ($urandom_range(0, 3) == 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    reload = 1'b0;
  endtask

  task automatic send_tx(input int maxgap);
    foreach (tx[i]) send_byte(tx[i], maxgap, 1'b0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clr_logs();
    dut_log.delete();
    mdl_log.delete();
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] addr,
                        input logic [31:0] data);
    if (idx < dut_log.size()) begin
      chk({nm, "_addr"}, dut_log[idx].addr, addr);
      chk({nm, "_data"}, dut_log[idx].data, data);
    end else chk({nm, "_present"}, 32'(dut_log.size()), 32'(idx + 1));
    if (idx < mdl_log.size()) chk({nm, "_model"}, mdl_log[idx].data, data);
    else chk({nm, "_model_present"}, 32'(mdl_log.size()), 32'(idx + 1));
  endtask

  int nw;
  logic [7:0] rb;

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(bus.byte_ready), 32'd1);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_we",      32'(bus.mem_we), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_err",     32'(err), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Two-word image, back-to-back
    clr_logs();
    tx = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    send_tx(0);
    chk("t1_we_last", 32'(bus.mem_we), 32'd1);
    chk("t1_done_in_we", 32'(done), 32'd1);
    chk("t1_cpu_rst_held", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("t1_cpu_rst_rel", 32'(cpu_rst), 32'd0);
    chk_wr("t1_w0", 0, 32'd0, 32'h00A00513);
    chk_wr("t1_w1", 1, 32'd1, 32'h00150593);
    chk("t1_nwr", 32'(dut_log.size()), 32'd2);

    // byte_valid in DONE is not consumed
    bus.byte_valid = 1'b1; bus.byte_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("done_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;

    // Empty image
    pulse_reload();
    clr_logs();
    tx = {8'h00, 8'h00};
    send_tx(1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cpu_rst_held", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("t2_cpu_rst_rel", 32'(cpu_rst), 32'd0);
    chk("t2_nwr", 32'(dut_log.size()), 32'd0);

    // Gapped single word
    pulse_reload();
    clr_logs();
    tx = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_tx(3);
    repeat (3) @(negedge clk);
    chk_wr("t3_w0", 0, 32'd0, 32'hDEADBEEF);
    chk("t3_nwr", 32'(dut_log.size()), 32'd1);

    // Reload with spurious reload pulses mid-image
    pulse_reload();
    clr_logs();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h78, 1, 1'b1);
    send_byte(8'h56, 1, 1'b1);
    send_byte(8'h34, 1, 1'b1);
    send_byte(8'h12, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk_wr("t4_w0", 0, 32'd0, 32'h12345678);
    chk("t4_cpu_rst_rel", 32'(cpu_rst), 32'd0);

    // Reset mid-image, then resend
    pulse_reload();
    clr_logs();
    tx = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_tx(0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_we",    32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
    chk("mid_rst_cpu",   32'(cpu_rst), 32'd1);
    chk("mid_rst_ready", 32'(bus.byte_ready), 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    tx = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_tx(0);
    repeat (3) @(negedge clk);
    chk_wr("t5_w0", 0, 32'd0, 32'h44332211);
    chk("t5_nwr", 32'(dut_log.size()), 32'd1);

    // Oversized length parks in ERR
    do_reset();
    clr_logs();
    tx = {8'h01, 8'h01};
    send_tx(0);
    chk("t6_err", 32'(err), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1, 1'b0);
    chk("t6_err_hold", 32'(err), 32'd1);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_nwr", 32'(dut_log.size()), 32'd0);
    do_reset();
    chk("t6_err_clr", 32'(err), 32'd0);

    // Randomized images
    for (int it = 0; it < 25; it++) begin
      int r, gap;
      r   = int'($urandom_range(0, 19));
      gap = int'($urandom_range(0, 2));
      if (r < 2)        nw = 0;
      else if (r < 17)  nw = int'($urandom_range(1, 6));
      else if (r == 17) nw = 256;
      else              nw = int'($urandom_range(257, 65535));
      send_byte(8'(nw), gap, 1'b0);
      send_byte(8'(nw >> 8), gap, 1'b0);
      if (nw > 256) begin
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), gap, 1'b0);
      end else begin
        for (int i = 0; i < 4 * nw; i++) begin
          rb = 8'($urandom);
          send_byte(rb, gap, 1'b1);
        end
      end
      repeat (3) @(negedge clk);
      if (nw > 256 || $urandom_range(0, 1) == 0) do_reset();
      else pulse_reload();
    end

    // Full capacity image
    do_reset();
    clr_logs();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    for (int i = 0; i < 1024; i++) send_byte(8'(i * 7 + 3), 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("cap_nwr", 32'(dut_log.size()), 32'd256);
    if (dut_log.size() == 256) chk("cap_last_addr", dut_log[255].addr, 32'd255);
    chk("cap_done", 32'(done), 32'd1);
    chk("cap_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
